// File: rtl/can_defs.sv
// Shared CAN transmit-scheduler types: frame layout, mailbox count, FSM states and the
// arbitration priority key.
package can_defs;

  localparam int unsigned MbNum = 3;

  typedef struct packed {
    logic            ide;
    logic [10:0]     id_std;
    logic [28:0]     id_ext;
    logic            rtr;
    logic [3:0]      dlc;
    logic [7:0][7:0] data;
  } can_frame_t;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StActive
  } state_e;

  // Bit order follows the on-wire arbitration field, so the numerically lowest key wins the bus.
  function automatic logic [31:0] prio_key(input can_frame_t f);
    logic [31:0] key;
    if (f.ide) begin
      key = {f.id_ext[28:18], 1'b1, 1'b1, f.id_ext[17:0], f.rtr};
    end else begin
      key = {f.id_std, f.rtr, 1'b0, 18'd0, 1'b0};
    end
    return key;
  endfunction

endpackage

// File: rtl/can_tx_prio_cmp.sv
// Combinational 3-way arbitration: lowest priority key among pending mailboxes,
// ties resolved towards the lower mailbox index.
module can_tx_prio_cmp import can_defs::*; (
  input  can_frame_t       i_frames [MbNum],
  input  logic [MbNum-1:0] i_pending,
  output logic [1:0]       o_win_idx,
  output logic             o_win_valid
);

  logic [31:0] w_keys [MbNum];
  logic [31:0] w_best;
  logic [1:0]  w_idx;
  logic        w_valid;

  always_comb begin
    for (int i = 0; i < MbNum; i++) begin
      w_keys[i] = prio_key(i_frames[i]);
    end
  end

  // Strict less-than keeps the earlier (lower) index on equal keys.
  always_comb begin
    w_best  = '1;
    w_idx   = '0;
    w_valid = 1'b0;
    for (int i = 0; i < MbNum; i++) begin
      if (i_pending[i] && (!w_valid || (w_keys[i] < w_best))) begin
        w_best  = w_keys[i];
        w_idx   = 2'(i);
        w_valid = 1'b1;
      end
    end
  end

  assign o_win_idx   = w_idx;
  assign o_win_valid = w_valid;

endmodule

// File: rtl/can_tx_scheduler.sv
// Three-mailbox CAN transmit scheduler: holds frames, arbitrates by CAN priority and
// hands the winner to the transmitter, handling completion, lost arbitration and aborts.
module can_tx_scheduler import can_defs::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mb_wr_en,
  input  logic [1:0]       mb_wr_sel,
  input  can_frame_t       mb_wr_frame,
  input  logic [MbNum-1:0] abort_req,
  input  logic             bus_idle,
  input  logic             tx_done,
  input  logic             arb_lost,
  output logic             start_tx,
  output logic             ide,
  output logic [10:0]      id_std,
  output logic [28:0]      id_ext,
  output logic             rtr,
  output logic [3:0]       dlc,
  output logic [7:0]       tx_data_0,
  output logic [7:0]       tx_data_1,
  output logic [7:0]       tx_data_2,
  output logic [7:0]       tx_data_3,
  output logic [7:0]       tx_data_4,
  output logic [7:0]       tx_data_5,
  output logic [7:0]       tx_data_6,
  output logic [7:0]       tx_data_7,
  output logic [MbNum-1:0] mb_pending,
  output logic [MbNum-1:0] mb_done,
  output logic [MbNum-1:0] mb_aborted,
  output logic             busy,
  output logic             wr_err
);

  state_e           r_state, w_state_d;
  can_frame_t       r_mb [MbNum];
  can_frame_t       r_frame;
  logic [MbNum-1:0] r_pending, w_pending_d;
  logic [MbNum-1:0] r_mb_done, w_mb_done_d;
  logic [MbNum-1:0] r_mb_aborted, w_mb_aborted_d;
  logic [1:0]       r_act_idx;
  logic             r_defer, w_defer_d;
  logic             r_wr_err;

  logic [1:0]       w_win_idx;
  logic             w_win_valid;
  logic [MbNum-1:0] w_win_mask;
  logic [MbNum-1:0] w_act_mask;
  logic [MbNum-1:0] w_wr_hit;
  logic             w_sel_ok;
  logic             w_wr_drop;
  logic             w_wr_do;
  logic [MbNum-1:0] w_abort_now;
  logic             w_abort_defer;
  logic             w_done;
  logic             w_lost;
  logic             w_win_touched;
  logic             w_latch;

  can_tx_prio_cmp u_prio_cmp (
    .i_frames    (r_mb),
    .i_pending   (r_pending),
    .o_win_idx   (w_win_idx),
    .o_win_valid (w_win_valid)
  );

  always_comb begin
    w_sel_ok      = (mb_wr_sel < 2'(MbNum));
    w_act_mask    = (r_state != StIdle) ? (3'b001 << r_act_idx) : 3'b000;
    w_wr_hit      = (mb_wr_en && w_sel_ok) ? (3'b001 << mb_wr_sel) : 3'b000;
    w_win_mask    = w_win_valid ? (3'b001 << w_win_idx) : 3'b000;
    w_wr_drop     = mb_wr_en && (!w_sel_ok || (|(w_wr_hit & (abort_req | w_act_mask))));
    w_wr_do       = mb_wr_en && !w_wr_drop;
    w_abort_now   = abort_req & r_pending & ~w_act_mask;
    w_abort_defer = |(abort_req & w_act_mask);
    w_done        = (r_state == StActive) && tx_done;
    w_lost        = (r_state == StActive) && arb_lost && !tx_done;
    // Hold off selection for one cycle if the winner is being rewritten or aborted right now.
    w_win_touched = |(w_win_mask & (w_wr_hit | abort_req));
  end

  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_win_valid && bus_idle && !w_win_touched) begin
          w_state_d = StStart;
          w_latch   = 1'b1;
        end
      end
      StStart:  w_state_d = StActive;
      StActive: if (tx_done || arb_lost) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_pending_d    = r_pending & ~w_abort_now;
    w_mb_done_d    = '0;
    w_mb_aborted_d = w_abort_now;
    w_defer_d      = r_defer | w_abort_defer;
    if (w_wr_do) w_pending_d = w_pending_d | w_wr_hit;
    if (w_done) begin
      w_pending_d = w_pending_d & ~w_act_mask;
      w_mb_done_d = w_act_mask;
      w_defer_d   = 1'b0;
    end else if (w_lost) begin
      w_defer_d = 1'b0;
      if (r_defer || w_abort_defer) begin
        w_pending_d    = w_pending_d & ~w_act_mask;
        w_mb_aborted_d = w_mb_aborted_d | w_act_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_pending    <= '0;
      r_mb_done    <= '0;
      r_mb_aborted <= '0;
      r_act_idx    <= '0;
      r_defer      <= 1'b0;
      r_wr_err     <= 1'b0;
      r_frame      <= '0;
      for (int i = 0; i < MbNum; i++) begin
        r_mb[i] <= '0;
      end
    end else begin
      r_state      <= w_state_d;
      r_pending    <= w_pending_d;
      r_mb_done    <= w_mb_done_d;
      r_mb_aborted <= w_mb_aborted_d;
      r_defer      <= w_defer_d;
      r_wr_err     <= w_wr_drop;
      if (w_latch) begin
        r_act_idx <= w_win_idx;
        r_frame   <= r_mb[w_win_idx];
      end
      for (int i = 0; i < MbNum; i++) begin
        if (w_wr_do && (mb_wr_sel == 2'(i))) r_mb[i] <= mb_wr_frame;
      end
    end
  end

  assign start_tx   = (r_state == StStart);
  assign busy       = (r_state != StIdle);
  assign wr_err     = r_wr_err;
  assign mb_pending = r_pending;
  assign mb_done    = r_mb_done;
  assign mb_aborted = r_mb_aborted;
  assign ide        = r_frame.ide;
  assign id_std     = r_frame.id_std;
  assign id_ext     = r_frame.id_ext;
  assign rtr        = r_frame.rtr;
  assign dlc        = r_frame.dlc;
  assign tx_data_0  = r_frame.data[0];
  assign tx_data_1  = r_frame.data[1];
  assign tx_data_2  = r_frame.data[2];
  assign tx_data_3  = r_frame.data[3];
  assign tx_data_4  = r_frame.data[4];
  assign tx_data_5  = r_frame.data[5];
  assign tx_data_6  = r_frame.data[6];
  assign tx_data_7  = r_frame.data[7];

endmodule
